// File: rtl/pipe_defs.sv
// Shared encodings and the RAW-match helper for the stall-only pipeline
// hazard controller.
package pipe_defs;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A writer to $0 never conflicts; otherwise match against each source the ID instruction reads.
    function automatic logic raw_hazard(
        input logic       wreg,
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return wreg && (rd != REG_ZERO) &&
               ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for the stall/flush statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count increment requests, holding once every bit is set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= {W{1'b0}};
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1'b1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush/redirect control for a 5-stage MIPS pipeline without
// forwarding, with saturating stall and redirect statistics.
module pipe_hazard_ctrl
    import pipe_defs::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ewreg,
    input  logic [4:0]       erdrt,
    input  logic             mwreg,
    input  logic [4:0]       mrdrt,
    input  logic             mbranch,
    input  logic             mzero,
    input  logic [31:0]      mpc,
    output logic             pc_wen,
    output logic             pc_sel,
    output logic [31:0]      br_target,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idexe_bubble,
    output logic             exemem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_err
);

    // Run counter only needs to reach MAX_STALL+1, where it saturates.
    localparam int               RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1'b1);

    state_t           r_state;
    state_t           w_next_state;
    logic [RUN_W-1:0] r_run;
    logic             r_stall_err;
    logic             w_hz_e;
    logic             w_hz_m;
    logic             w_taken;
    logic             w_stall;

    assign w_hz_e    = raw_hazard(ewreg, erdrt, id_rs, id_rt, id_use_rs, id_use_rt);
    assign w_hz_m    = raw_hazard(mwreg, mrdrt, id_rs, id_rt, id_use_rs, id_use_rt);
    assign w_taken   = mbranch & mzero;
    assign br_target = mpc;
    assign stall_err = r_stall_err;

    // Control outputs and next state; a taken branch overrides any stall.
    always_comb begin
        w_next_state = ST_RUN;
        w_stall      = 1'b0;
        pc_wen       = 1'b1;
        ifid_wen     = 1'b1;
        pc_sel       = 1'b0;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        exemem_flush = 1'b0;
        if (w_taken) begin
            pc_sel       = 1'b1;
            ifid_flush   = 1'b1;
            idexe_bubble = 1'b1;
            exemem_flush = 1'b1;
            w_next_state = ST_REDIRECT;
        end else begin
            case (r_state)
                ST_RUN, ST_STALL: begin
                    if (w_hz_e || w_hz_m) begin
                        w_stall      = 1'b1;
                        pc_wen       = 1'b0;
                        ifid_wen     = 1'b0;
                        idexe_bubble = 1'b1;
                        w_next_state = ST_STALL;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                // ID holds the flushed NOP, so its register fields are stale.
                ST_REDIRECT: w_next_state = ST_RUN;
                default:     w_next_state = ST_RUN;
            endcase
        end
    end

    // State, consecutive-stall run length and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_run       <= {RUN_W{1'b0}};
            r_stall_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_stall) begin
                if (r_run >= RUN_LIM) begin
                    r_stall_err <= 1'b1;
                end else begin
                    r_stall_err <= r_stall_err;
                end
                if (r_run <= RUN_LIM) begin
                    r_run <= r_run + RUN_ONE;
                end else begin
                    r_run <= r_run;
                end
            end else begin
                r_run       <= {RUN_W{1'b0}};
                r_stall_err <= r_stall_err;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_stall),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_taken),
        .o_cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed table, corner sequences and random
// stimulus against a behavioural model; a 4-bit-counter copy covers saturation.
module tb_pipe_hazard_ctrl;

    localparam int MAXS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  id_rs, id_rt, erdrt, mrdrt;
    logic        id_use_rs, id_use_rt, ewreg, mwreg, mbranch, mzero;
    logic [31:0] mpc;

    logic        pc_wen, pc_sel, ifid_wen, ifid_flush, idexe_bubble, exemem_flush, stall_err;
    logic [31:0] br_target;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_wen, s_pc_sel, s_ifid_wen, s_ifid_flush, s_idexe_bubble, s_exemem_flush, s_stall_err;
    logic [31:0] s_br_target;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(16), .MAX_STALL(MAXS)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ewreg(ewreg), .erdrt(erdrt), .mwreg(mwreg), .mrdrt(mrdrt),
        .mbranch(mbranch), .mzero(mzero), .mpc(mpc),
        .pc_wen(pc_wen), .pc_sel(pc_sel), .br_target(br_target),
        .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .idexe_bubble(idexe_bubble), .exemem_flush(exemem_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_err(stall_err)
    );

    pipe_hazard_ctrl #(.CNT_W(4), .MAX_STALL(MAXS)) dut_s (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ewreg(ewreg), .erdrt(erdrt), .mwreg(mwreg), .mrdrt(mrdrt),
        .mbranch(mbranch), .mzero(mzero), .mpc(mpc),
        .pc_wen(s_pc_wen), .pc_sel(s_pc_sel), .br_target(s_br_target),
        .ifid_wen(s_ifid_wen), .ifid_flush(s_ifid_flush),
        .idexe_bubble(s_idexe_bubble), .exemem_flush(s_exemem_flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .stall_err(s_stall_err)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Behavioural model: totals as plain integers, one flag for "last cycle redirected".
    bit m_redir;
    int m_stalls, m_flushes, m_run;
    bit m_err;
    bit e_taken, e_stall;

    typedef struct {
        bit          r;
        logic [4:0]  rs;
        bit          urs;
        bit          ew;
        logic [4:0]  erd;
        bit          mw;
        logic [4:0]  mrd;
        bit          br;
        logic [31:0] pc;
        bit          x_pcwen;
        bit          x_sel;
        bit          x_bub;
        int          x_scnt;
        int          x_fcnt;
        bit          x_err;
    } vec_t;

    vec_t tbl[16];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && ((id_use_rs && id_rs == r) || (id_use_rt && id_rt == r));
    endfunction

    function automatic int sat(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic drive(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                         input bit urs, input bit urt, input bit ew, input logic [4:0] erd,
                         input bit mw, input logic [4:0] mrd, input bit br, input bit z,
                         input logic [31:0] pc);
        rst = r; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        ewreg = ew; erdrt = erd; mwreg = mw; mrdrt = mrd;
        mbranch = br; mzero = z; mpc = pc;
    endtask

    task automatic idle(input bit r);
        drive(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic hazard_e();
        drive(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic sample_and_check();
        e_taken = mbranch && mzero;
        e_stall = !e_taken && !m_redir &&
                  ((ewreg && reads(erdrt)) || (mwreg && reads(mrdrt)));
        #4;
        chk1("pc_wen", pc_wen, !e_stall);
        chk1("ifid_wen", ifid_wen, !e_stall);
        chk1("pc_sel", pc_sel, e_taken);
        chk1("ifid_flush", ifid_flush, e_taken);
        chk1("exemem_flush", exemem_flush, e_taken);
        chk1("idexe_bubble", idexe_bubble, e_taken || e_stall);
        chkv("br_target", br_target, mpc);
        chkv("stall_cnt", 32'(stall_cnt), 32'(sat(m_stalls, 16)));
        chkv("flush_cnt", 32'(flush_cnt), 32'(sat(m_flushes, 16)));
        chk1("stall_err", stall_err, m_err);
        chk1("s_pc_wen", s_pc_wen, !e_stall);
        chk1("s_idexe_bubble", s_idexe_bubble, e_taken || e_stall);
        chk1("s_pc_sel", s_pc_sel, e_taken);
        chkv("s_stall_cnt", 32'(s_stall_cnt), 32'(sat(m_stalls, 4)));
        chkv("s_flush_cnt", 32'(s_flush_cnt), 32'(sat(m_flushes, 4)));
        chk1("s_stall_err", s_stall_err, m_err);
        if (s_ifid_wen !== s_pc_wen || s_ifid_flush !== s_exemem_flush || s_br_target !== mpc) begin
            n_tot++;
            $display("FAIL s_misc: ifid_wen=%0b ifid_flush=%0b br_target=%0h", s_ifid_wen, s_ifid_flush, s_br_target);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_redir = 1'b0; m_stalls = 0; m_flushes = 0; m_run = 0; m_err = 1'b0;
        end else if (e_taken) begin
            m_flushes++; m_run = 0; m_redir = 1'b1;
        end else if (e_stall) begin
            m_stalls++; m_run++; m_redir = 1'b0;
            if (m_run > MAXS) m_err = 1'b1;
        end else begin
            m_run = 0; m_redir = 1'b0;
        end
        #1;
    endtask

    task automatic step();
        sample_and_check();
        advance();
    endtask

    initial begin
        m_redir = 1'b0; m_stalls = 0; m_flushes = 0; m_run = 0; m_err = 1'b0;
        //           r  rs   urs ew erd   mw mrd   br pc        pcwen sel bub scnt fcnt err
        tbl[0]  = '{1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 32'h0,     1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 32'h0,     1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 5'd5, 1, 1, 5'd5, 0, 5'd0, 0, 32'h0,     0, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 5'd5, 1, 0, 5'd0, 1, 5'd5, 0, 32'h0,     0, 0, 1, 1, 0, 0};
        tbl[4]  = '{0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 32'h0,     1, 0, 0, 2, 0, 0};
        tbl[5]  = '{0, 5'd0, 1, 1, 5'd0, 0, 5'd0, 0, 32'h0,     1, 0, 0, 2, 0, 0};
        tbl[6]  = '{0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 32'h0,     1, 0, 0, 2, 0, 0};
        tbl[7]  = '{0, 5'd5, 1, 1, 5'd5, 0, 5'd0, 1, 32'h40,    1, 1, 1, 2, 0, 0};
        tbl[8]  = '{0, 5'd5, 1, 1, 5'd5, 0, 5'd0, 0, 32'h0,     1, 0, 0, 2, 1, 0};
        tbl[9]  = '{0, 5'd5, 1, 1, 5'd5, 0, 5'd0, 0, 32'h0,     0, 0, 1, 2, 1, 0};
        tbl[10] = '{0, 5'd5, 1, 1, 5'd5, 0, 5'd0, 0, 32'h0,     0, 0, 1, 3, 1, 0};
        tbl[11] = '{0, 5'd5, 1, 1, 5'd5, 0, 5'd0, 0, 32'h0,     0, 0, 1, 4, 1, 0};
        tbl[12] = '{0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 32'h0,     1, 0, 0, 5, 1, 1};
        tbl[13] = '{0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 32'h0,     1, 0, 0, 5, 1, 1};
        tbl[14] = '{1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 32'h0,     1, 0, 0, 5, 1, 1};
        tbl[15] = '{0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 32'h0,     1, 0, 0, 0, 0, 0};

        idle(1'b1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].r, tbl[i].rs, 5'd0, tbl[i].urs, 1'b0, tbl[i].ew, tbl[i].erd,
                  tbl[i].mw, tbl[i].mrd, tbl[i].br, tbl[i].br, tbl[i].pc);
            sample_and_check();
            chk1($sformatf("row%0d_pc_wen", i), pc_wen, tbl[i].x_pcwen);
            chk1($sformatf("row%0d_ifid_wen", i), ifid_wen, tbl[i].x_pcwen);
            chk1($sformatf("row%0d_pc_sel", i), pc_sel, tbl[i].x_sel);
            chk1($sformatf("row%0d_flushes", i), ifid_flush & exemem_flush, tbl[i].x_sel);
            chk1($sformatf("row%0d_bubble", i), idexe_bubble, tbl[i].x_bub);
            chkv($sformatf("row%0d_stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].x_scnt));
            chkv($sformatf("row%0d_flush_cnt", i), 32'(flush_cnt), 32'(tbl[i].x_fcnt));
            chk1($sformatf("row%0d_stall_err", i), stall_err, tbl[i].x_err);
            if (tbl[i].x_sel) chkv($sformatf("row%0d_br_target", i), br_target, 32'h40);
            advance();
        end

        // Stall counter saturation on the 4-bit copy, then reset mid-stall.
        idle(1'b1); step();
        for (int i = 0; i < 20; i++) begin hazard_e(); step(); end
        idle(1'b0);
        sample_and_check();
        chkv("sat_s_stall_cnt", 32'(s_stall_cnt), 32'hF);
        chkv("sat_stall_cnt", 32'(stall_cnt), 32'd20);
        advance();
        hazard_e(); step();
        drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0); step();
        idle(1'b0);
        sample_and_check();
        chk1("rst_midstall_pc_wen", pc_wen, 1'b1);
        chkv("rst_midstall_cnt", 32'(stall_cnt), 32'd0);
        chk1("rst_midstall_err", stall_err, 1'b0);
        advance();

        // Redirect counter saturation: back-to-back taken branches.
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b1, 32'h100 + 32'(i));
            step();
        end
        idle(1'b0);
        sample_and_check();
        chkv("sat_s_flush_cnt", 32'(s_flush_cnt), 32'hF);
        chkv("sat_flush_cnt", 32'(flush_cnt), 32'd17);
        advance();

        // Reset during redirect: the following hazard must stall, not be ignored.
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h80); step();
        drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0); step();
        hazard_e();
        sample_and_check();
        chk1("rst_redirect_stall", pc_wen, 1'b0);
        chk1("rst_redirect_no_flush", ifid_flush, 1'b0);
        advance();

        // Randomized traffic with a narrow register range to provoke matches.
        idle(1'b1); step();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 39) == 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                  32'($urandom));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
